// File: rtl/memory_writer.sv
// memory_writer: output stage of the bytecode-to-ARM translator.
// Appends 1..MAX_WORDS packed 32-bit instruction words per request to an
// internal instruction memory, most-significant valid word first, and exposes
// a combinational read port for dumping the generated program.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset (clears word_count/full only)
//   write_enable  commit request, level-sensitive, sampled every rising edge
//   instructions  packed words, word k = bits[32k+31:32k]
//   quantity      number of valid words (0..15, clamped to MAX_WORDS)
//   rd_addr       read address
//   rd_data       mem[rd_addr], combinational
//   word_count    words stored so far (next write address), saturates at DEPTH
//   full          sticky flag: a word was dropped for lack of space
`timescale 1ns/1ps

module memory_writer #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned MAX_WORDS = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write_enable,
    input  logic [32*MAX_WORDS-1:0]   instructions,
    input  logic [3:0]                quantity,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [31:0]               rd_data,
    output logic [ADDR_W:0]           word_count,
    output logic                      full
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    // One extra bit so word_count + slot index never wraps before the DEPTH compare
    localparam int unsigned EXT_W  = ADDR_W + 2;
    localparam int unsigned SEL_W  = $clog2(MAX_WORDS);
    localparam int unsigned N_W    = $clog2(MAX_WORDS + 1);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [N_W-1:0]    n;
    logic [WORD_W-1:0] words    [MAX_WORDS];
    logic [CNT_W-1:0]  avail;
    logic [CNT_W-1:0]  stored;
    logic              dropped;
    logic [EXT_W-1:0]  addr_ext [MAX_WORDS];
    logic [ADDR_W-1:0] wr_addr  [MAX_WORDS];
    logic [WORD_W-1:0] wr_data  [MAX_WORDS];
    logic              wr_en    [MAX_WORDS];

    // Clamp the requested word count and split the packed bus into words
    always_comb begin
        if (quantity > 4'(MAX_WORDS)) begin
            n = N_W'(MAX_WORDS);
        end else begin
            n = N_W'(quantity);
        end
        for (int i = 0; i < MAX_WORDS; i++) begin
            words[i] = instructions[WORD_W*i +: WORD_W];
        end
    end

    // Space left and how many of the n words actually fit
    always_comb begin
        avail   = CNT_W'(DEPTH) - word_count;
        stored  = CNT_W'(n);
        dropped = 1'b0;
        if (CNT_W'(n) > avail) begin
            stored  = avail;
            dropped = 1'b1;
        end
    end

    // Slot j stores word n-1-j at word_count+j; slots past DEPTH are dropped
    always_comb begin
        for (int j = 0; j < MAX_WORDS; j++) begin
            addr_ext[j] = EXT_W'(word_count) + EXT_W'(j);
            wr_addr[j]  = addr_ext[j][ADDR_W-1:0];
            wr_data[j]  = '0;
            wr_en[j]    = 1'b0;
            if (j < int'(n)) begin
                wr_data[j] = words[SEL_W'(int'(n) - 1 - j)];
                wr_en[j]   = write_enable && (addr_ext[j] < EXT_W'(DEPTH));
            end
        end
    end

    // Instruction memory: not cleared by reset, but reset blocks a commit
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < MAX_WORDS; j++) begin
                if (wr_en[j]) begin
                    mem[wr_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    // Write pointer and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
            full       <= 1'b0;
        end else if (write_enable && (n != '0)) begin
            word_count <= word_count + stored;
            if (dropped) begin
                full <= 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_memory_writer.sv
// Scoreboard bench for memory_writer: a large instance (DEPTH=256) for the
// append/ordering behaviour and a small instance (DEPTH=8) for overflow.
`timescale 1ns/1ps

module tb_memory_writer;

    localparam int K_CNT  = 0;
    localparam int K_FULL = 1;
    localparam int K_MEM  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH 256
    logic         reset_a = 1'b1;
    logic         we_a    = 1'b0;
    logic [191:0] instr_a = '0;
    logic [3:0]   qty_a   = '0;
    logic [7:0]   rd_addr_a = '0;
    logic [31:0]  rd_data_a;
    logic [8:0]   wc_a;
    logic         full_a;

    // Instance B: DEPTH 8
    logic         reset_b = 1'b1;
    logic         we_b    = 1'b0;
    logic [191:0] instr_b = '0;
    logic [3:0]   qty_b   = '0;
    logic [2:0]   rd_addr_b = '0;
    logic [31:0]  rd_data_b;
    logic [3:0]   wc_b;
    logic         full_b;

    memory_writer #(.DEPTH(256), .ADDR_W(8), .MAX_WORDS(6)) dut_a (
        .clk(clk), .reset(reset_a), .write_enable(we_a), .instructions(instr_a),
        .quantity(qty_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .word_count(wc_a), .full(full_a)
    );

    memory_writer #(.DEPTH(8), .ADDR_W(3), .MAX_WORDS(6)) dut_b (
        .clk(clk), .reset(reset_b), .write_enable(we_b), .instructions(instr_b),
        .quantity(qty_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .word_count(wc_b), .full(full_b)
    );

    typedef struct {
        int          dut;
        int          kind;
        int          addr;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [191:0] pack6(input logic [31:0] w5, input logic [31:0] w4,
                                           input logic [31:0] w3, input logic [31:0] w2,
                                           input logic [31:0] w1, input logic [31:0] w0);
        return {w5, w4, w3, w2, w1, w0};
    endfunction

    task automatic push(input int dut, input int kind, input int addr,
                        input logic [31:0] e, input string nm);
        exp_t it;
        it.dut  = dut;
        it.kind = kind;
        it.addr = addr;
        it.exp  = e;
        it.name = nm;
        sbq.push_back(it);
    endtask

    // Monitor: register checks all at once, at most one memory read per cycle
    always @(negedge clk) begin
        exp_t        it;
        logic [31:0] act;
        bit          done;
        done = 1'b0;
        while (!done && sbq.size() > 0) begin
            it = sbq.pop_front();
            if (it.kind == K_MEM) begin
                if (it.dut == 0) rd_addr_a = 8'(it.addr);
                else             rd_addr_b = 3'(it.addr);
                #1;
                act  = (it.dut == 0) ? rd_data_a : rd_data_b;
                done = 1'b1;
            end else if (it.kind == K_CNT) begin
                act = (it.dut == 0) ? 32'(wc_a) : 32'(wc_b);
            end else begin
                act = (it.dut == 0) ? 32'(full_a) : 32'(full_b);
            end
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() > 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic commit(input int dut, input logic [191:0] ins, input logic [3:0] q,
                          input int cycles);
        @(posedge clk);
        #2;
        if (dut == 0) begin instr_a = ins; qty_a = q; we_a = 1'b1; end
        else          begin instr_b = ins; qty_b = q; we_b = 1'b1; end
        repeat (cycles) @(posedge clk);
        #2;
        if (dut == 0) we_a = 1'b0;
        else          we_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state on both instances
        #12;
        push(0, K_CNT, 0, 32'd0, "a_rst_cnt");
        push(0, K_FULL, 0, 32'd0, "a_rst_full");
        push(1, K_CNT, 0, 32'd0, "b_rst_cnt");
        push(1, K_FULL, 0, 32'd0, "b_rst_full");
        drain();
        @(posedge clk);
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Idle cycles leave the pointer alone
        repeat (5) @(posedge clk);
        #2;
        push(0, K_CNT, 0, 32'd0, "a_idle_cnt");
        drain();

        // Two words, most-significant first
        commit(0, pack6(0, 0, 0, 0, 32'hE92D0002, 32'hE3A01000), 4'd2, 1);
        push(0, K_MEM, 0, 32'hE92D0002, "a_q2_mem0");
        push(0, K_MEM, 1, 32'hE3A01000, "a_q2_mem1");
        push(0, K_CNT, 0, 32'd2, "a_q2_cnt");
        drain();

        // Six words 6..1
        commit(0, pack6(6, 5, 4, 3, 2, 1), 4'd6, 1);
        for (int i = 0; i < 6; i++) push(0, K_MEM, 2 + i, 32'(6 - i), "a_q6_mem");
        push(0, K_CNT, 0, 32'd8, "a_q6_cnt");
        drain();

        // quantity 0 does nothing, quantity 9 clamps to 6
        commit(0, {6{32'h55555555}}, 4'd0, 1);
        push(0, K_CNT, 0, 32'd8, "a_q0_cnt");
        drain();
        commit(0, {6{32'hAAAAAAAA}}, 4'd9, 1);
        for (int i = 8; i < 14; i++) push(0, K_MEM, i, 32'hAAAAAAAA, "a_q9_mem");
        push(0, K_MEM, 7, 32'd1, "a_q9_prev_mem7");
        push(0, K_CNT, 0, 32'd14, "a_q9_cnt");
        push(0, K_FULL, 0, 32'd0, "a_q9_full");
        drain();

        // Words above n are ignored
        commit(0, pack6(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'h33, 32'h22, 32'h11), 4'd3, 1);
        push(0, K_MEM, 14, 32'h33, "a_q3_mem14");
        push(0, K_MEM, 15, 32'h22, "a_q3_mem15");
        push(0, K_MEM, 16, 32'h11, "a_q3_mem16");
        push(0, K_CNT, 0, 32'd17, "a_q3_cnt");
        drain();

        // Level-sensitive: held 3 cycles appends 3 times
        commit(0, pack6(32'hBAD, 32'hBAD, 32'hBAD, 32'hBAD, 32'hBAD, 32'hCAFE0001), 4'd1, 3);
        for (int i = 17; i < 20; i++) push(0, K_MEM, i, 32'hCAFE0001, "a_hold_mem");
        push(0, K_CNT, 0, 32'd20, "a_hold_cnt");
        drain();

        // quantity 15 clamps to 6
        commit(0, pack6(32'hF6, 32'hF5, 32'hF4, 32'hF3, 32'hF2, 32'hF1), 4'd15, 1);
        push(0, K_MEM, 20, 32'hF6, "a_q15_mem20");
        push(0, K_MEM, 25, 32'hF1, "a_q15_mem25");
        push(0, K_CNT, 0, 32'd26, "a_q15_cnt");
        drain();

        // Reset during a commit: pointer cleared, no write, memory retained
        @(posedge clk);
        #2;
        instr_a = pack6(0, 0, 0, 0, 0, 32'h12345678);
        qty_a   = 4'd1;
        we_a    = 1'b1;
        reset_a = 1'b1;
        @(posedge clk);
        #2;
        we_a = 1'b0;
        push(0, K_CNT, 0, 32'd0, "a_rstcommit_cnt");
        push(0, K_MEM, 0, 32'hE92D0002, "a_rstcommit_mem0");
        drain();
        @(posedge clk);
        #2;
        reset_a = 1'b0;

        // Small instance: fill 6 of 8
        commit(1, pack6(32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0), 4'd6, 1);
        push(1, K_MEM, 0, 32'hB5, "b_fill_mem0");
        push(1, K_MEM, 5, 32'hB0, "b_fill_mem5");
        push(1, K_CNT, 0, 32'd6, "b_fill_cnt");
        push(1, K_FULL, 0, 32'd0, "b_fill_full");
        drain();

        // Three words with two slots left: third dropped, full set
        commit(1, pack6(0, 0, 0, 32'hC2, 32'hC1, 32'hC0), 4'd3, 1);
        push(1, K_MEM, 6, 32'hC2, "b_ovf_mem6");
        push(1, K_MEM, 7, 32'hC1, "b_ovf_mem7");
        push(1, K_MEM, 0, 32'hB5, "b_ovf_nowrap_mem0");
        push(1, K_CNT, 0, 32'd8, "b_ovf_cnt");
        push(1, K_FULL, 0, 32'd1, "b_ovf_full");
        drain();

        // Commit while saturated writes nothing, flag stays
        commit(1, pack6(0, 0, 0, 0, 0, 32'hEE), 4'd1, 1);
        push(1, K_MEM, 0, 32'hB5, "b_sat_mem0");
        push(1, K_MEM, 7, 32'hC1, "b_sat_mem7");
        push(1, K_CNT, 0, 32'd8, "b_sat_cnt");
        push(1, K_FULL, 0, 32'd1, "b_sat_full");
        drain();

        // Asynchronous reset between edges clears before the next edge
        @(posedge clk);
        #3;
        reset_b = 1'b1;
        push(1, K_CNT, 0, 32'd0, "b_async_cnt");
        push(1, K_FULL, 0, 32'd0, "b_async_full");
        drain();
        @(posedge clk);
        #2;
        reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        push(1, K_FULL, 0, 32'd0, "b_after_rst_full");
        push(1, K_MEM, 0, 32'hB5, "b_after_rst_mem0");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
